// File: rtl/tinker_arb_pkg.sv
// Shared types and constants for the tinker_core memory-port arbiter.
// Latency: n/a (types only). Backpressure: n/a.
package tinker_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SRV_F = 2'd1,
        SRV_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam logic [63:0] MEM_TEXT_BASE = 64'h2000;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/tinker_arb_streak.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
// Latency: at_max reflects the count one cycle after inc. Backpressure: none.
module tinker_arb_streak #(
    parameter int MAX_STREAK = 4,
    parameter int SW         = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [SW-1:0] MAXV = SW'(MAX_STREAK);

    logic [SW-1:0] streak;

    always_ff @(posedge clk) begin
        if (!reset) begin
            streak <= '0;
        end else if (clr) begin
            streak <= '0;
        end else if (inc && !at_max) begin
            streak <= streak + SW'(1);
        end
    end

    assign at_max = (streak == MAXV);

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Fetch/LSU arbiter onto one memory port; TINKER_ARB_STATS_EN adds saturating grant/wait counters.
// Latency: grant 1 cycle after request seen idle, valid 1 cycle after m_ack; 2 cycles overhead back-to-back.
// Backpressure: requests wait while busy; data wins, but fetch is forced after MAX_STREAK data grants.
module tinker_mem_arbiter
    import tinker_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int MAX_STREAK = 4,
    parameter int SW         = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [31:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [63:0]       d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic              m_wide,
    output logic [ADDR_W-1:0] m_addr,
    output logic [63:0]       m_wdata,
    input  logic              m_ack,
    input  logic [63:0]       m_rdata,
    output logic              busy
`ifdef TINKER_ARB_STATS_EN
    ,
    output logic [31:0]       stat_f_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_f_wait,
    output logic [31:0]       stat_forced
`endif
);

    arb_state_t        state, state_nxt;
    req_id_t           owner;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [63:0]       wdata_q;
    logic              first_q;

    logic f_elig, pick_d, pick_f, at_max, str_inc, str_clr;

    assign f_elig  = f_req & ~halt;
    assign pick_d  = (state == IDLE) & d_req & ~(f_elig & at_max);
    assign pick_f  = (state == IDLE) & f_elig & ~pick_d;
    assign str_inc = pick_d & f_elig;
    assign str_clr = pick_f | ((state == IDLE) & ~f_elig);

    tinker_arb_streak #(
        .MAX_STREAK (MAX_STREAK),
        .SW         (SW)
    ) u_streak (
        .clk    (clk),
        .reset  (reset),
        .inc    (str_inc),
        .clr    (str_clr),
        .at_max (at_max)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = SRV_D;
                end else if (pick_f) begin
                    state_nxt = SRV_F;
                end
            end
            SRV_F, SRV_D: begin
                if (m_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is latched at grant so the memory side sees stable fields even if the requester moves on.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner   <= REQ_F;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            first_q <= 1'b0;
            f_rdata <= '0;
            d_rdata <= '0;
        end else begin
            first_q <= pick_d | pick_f;
            if (pick_d) begin
                owner   <= REQ_D;
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_wdata;
            end else if (pick_f) begin
                owner   <= REQ_F;
                addr_q  <= f_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end
            if (state == SRV_F && m_ack) begin
                f_rdata <= m_rdata[31:0];
            end
            if (state == SRV_D && m_ack) begin
                d_rdata <= we_q ? '0 : m_rdata;
            end
        end
    end

    always_comb begin
        m_req   = (state == SRV_F) | (state == SRV_D);
        m_wide  = (state == SRV_D);
        m_we    = (state == SRV_D) & we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        f_gnt   = (state == SRV_F) & first_q;
        d_gnt   = (state == SRV_D) & first_q;
        f_valid = (state == DONE) & (owner == REQ_F);
        d_valid = (state == DONE) & (owner == REQ_D);
        busy    = (state != IDLE);
    end

`ifdef TINKER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_f_grants <= '0;
            stat_d_grants <= '0;
            stat_f_wait   <= '0;
            stat_forced   <= '0;
        end else begin
            if (pick_f) stat_f_grants <= sat_inc32(stat_f_grants);
            if (pick_d) stat_d_grants <= sat_inc32(stat_d_grants);
            if (f_elig && state != SRV_F) stat_f_wait <= sat_inc32(stat_f_wait);
            if (pick_f && d_req) stat_forced <= sat_inc32(stat_forced);
        end
    end
`endif

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Bench for tinker_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_tinker_mem_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset, halt;
    logic        f_req, f_gnt, f_valid;
    logic [63:0] f_addr;
    logic [31:0] f_rdata;
    logic        d_req, d_we, d_gnt, d_valid;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_wide, m_ack;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic        busy;
`ifdef TINKER_ARB_STATS_EN
    logic [31:0] stat_f_grants, stat_d_grants, stat_f_wait, stat_forced;
`endif

    always #5 clk = ~clk;

    tinker_mem_arbiter dut (
        .clk(clk), .reset(reset), .halt(halt),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_wide(m_wide), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
`ifdef TINKER_ARB_STATS_EN
        , .stat_f_grants(stat_f_grants), .stat_d_grants(stat_d_grants),
        .stat_f_wait(stat_f_wait), .stat_forced(stat_forced)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Byte-addressed backing store behind the memory port.
    bit [7:0] mem [logic [63:0]];

    function automatic logic [63:0] rd64(input logic [63:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mem.exists(a + 64'(i)) ? mem[a + 64'(i)] : 8'h00;
        return r;
    endfunction

    task automatic wr64(input logic [63:0] a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) mem[a + 64'(i)] = v[8*i +: 8];
    endtask

    int cyc = 0;
    // Requester modes: 0 off, 1 random, 2 continuous, 3 one-shot.
    int f_mode = 0, d_mode = 0;
    logic [63:0] f_addr_dir, d_addr_dir, d_wdata_dir;
    logic        d_we_dir;
    int fixed_lat = 0, cur_lat = 1, mcnt = 0;

    // Transaction-level reference state.
    bit          inflight = 0;
    int          owner_m = 0;               // 1 fetch, 2 data
    int          valid_due = 0, idle_from = 0, streak_m = 0;
    logic [63:0] exp_addr, exp_wdata, exp_data;
    logic        exp_we;
    logic [63:0] exp_f_rdata = 0, exp_d_rdata = 0;
    int          gq[$];
    int          f_gnt_cnt = 0, d_gnt_cnt = 0, d_valid_cnt = 0;
    int          last_f_gnt_cyc = 0, last_f_valid_cyc = 0;

    function automatic int gq_at(input int i);
        return (i < gq.size()) ? gq[i] : 0;
    endfunction

    function automatic logic [63:0] rand_faddr();
        if ($urandom_range(0, 1) == 1) return 64'h2000 + 64'(4 * $urandom_range(0, 15));
        return 64'h80000 + 64'(4 * $urandom_range(0, 31));
    endfunction

    task automatic model_step();
        bit fe, gf, gd, vf, vd;
        logic [63:0] t;
        gf = 0; gd = 0; vf = 0; vd = 0;
        if (!reset) begin
            inflight = 0; streak_m = 0; idle_from = cyc;
            exp_f_rdata = 0; exp_d_rdata = 0;
            chk("rst_ctrl", 64'({f_gnt, f_valid, d_gnt, d_valid, m_req, m_we, m_wide, busy}), 64'd0);
            chk("rst_f_rdata", 64'(f_rdata), 64'd0);
            chk("rst_d_rdata", d_rdata, 64'd0);
            chk("rst_m_addr", m_addr, 64'd0);
            chk("rst_m_wdata", m_wdata, 64'd0);
            return;
        end
        if (!inflight && (cyc - 1) >= idle_from) begin
            fe = f_req && !halt;
            if (d_req && !(fe && streak_m == MAXS)) begin
                gd = 1;
                streak_m = fe ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
            end else if (fe) begin
                gf = 1;
                streak_m = 0;
            end else begin
                streak_m = 0;
            end
            if (gf || gd) begin
                inflight  = 1;
                owner_m   = gf ? 1 : 2;
                cur_lat   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                valid_due = cyc + cur_lat;
                exp_addr  = gf ? f_addr : d_addr;
                exp_we    = gf ? 1'b0 : d_we;
                exp_wdata = d_wdata;
                t = rd64(exp_addr);
                exp_data  = gf ? {32'd0, t[31:0]} : (d_we ? 64'd0 : t);
            end
        end else if (inflight && cyc == valid_due) begin
            inflight  = 0;
            idle_from = cyc + 1;
            vf = (owner_m == 1);
            vd = (owner_m == 2);
            if (vf) exp_f_rdata = exp_data;
            if (vd) exp_d_rdata = exp_data;
        end
        chk("f_gnt", 64'(f_gnt), 64'(gf));
        chk("d_gnt", 64'(d_gnt), 64'(gd));
        chk("f_valid", 64'(f_valid), 64'(vf));
        chk("d_valid", 64'(d_valid), 64'(vd));
        chk("busy", 64'(busy), 64'(inflight | vf | vd));
        chk("m_req", 64'(m_req), 64'(inflight));
        chk("f_rdata", 64'(f_rdata), exp_f_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (inflight) begin
            chk("m_addr", m_addr, exp_addr);
            chk("m_wide", 64'(m_wide), 64'(owner_m == 2));
            chk("m_we", 64'(m_we), 64'(exp_we));
            if (exp_we) chk("m_wdata", m_wdata, exp_wdata);
        end
        if (f_gnt) begin gq.push_back(1); f_gnt_cnt++; last_f_gnt_cyc = cyc; end
        if (d_gnt) begin gq.push_back(2); d_gnt_cnt++; end
        if (f_valid) last_f_valid_cyc = cyc;
        if (d_valid) d_valid_cnt++;
    endtask

    task automatic mem_step();
        logic [63:0] t;
        m_ack   = 1'b0;
        m_rdata = {$urandom, $urandom};
        if (m_req) begin
            mcnt++;
            if (mcnt == cur_lat) begin
                m_ack = 1'b1;
                t = rd64(m_addr);
                if (m_we && m_wide) wr64(m_addr, m_wdata);
                else if (m_wide) m_rdata = t;
                else m_rdata = {$urandom, t[31:0]};
            end
        end else begin
            mcnt = 0;
        end
    endtask

    task automatic drive_step();
        if (f_req && f_valid) begin
            if (f_mode == 2) f_addr = f_addr_dir;
            else if (f_mode == 1 && $urandom_range(0, 1) == 1) f_addr = rand_faddr();
            else begin f_req = 1'b0; if (f_mode == 3) f_mode = 0; end
        end else if (!f_req) begin
            if (f_mode == 2 || f_mode == 3) begin f_req = 1'b1; f_addr = f_addr_dir; end
            else if (f_mode == 1 && $urandom_range(0, 3) == 0) begin f_req = 1'b1; f_addr = rand_faddr(); end
        end
        if (d_req && d_valid) begin
            if (d_mode == 2) begin d_addr = d_addr_dir; d_we = d_we_dir; d_wdata = d_wdata_dir; end
            else if (d_mode == 1 && $urandom_range(0, 1) == 1) begin
                d_addr = 64'h80000 + 64'(8 * $urandom_range(0, 15));
                d_we = 1'($urandom_range(0, 1)); d_wdata = {$urandom, $urandom};
            end else begin d_req = 1'b0; if (d_mode == 3) d_mode = 0; end
        end else if (!d_req) begin
            if (d_mode == 2 || d_mode == 3) begin
                d_req = 1'b1; d_addr = d_addr_dir; d_we = d_we_dir; d_wdata = d_wdata_dir;
            end else if (d_mode == 1 && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = 64'h80000 + 64'(8 * $urandom_range(0, 15));
                d_we = 1'($urandom_range(0, 1)); d_wdata = {$urandom, $urandom};
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        model_step();
        mem_step();
        drive_step();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((inflight || f_req || d_req) && n < budget) begin tick(); n++; end
        if (inflight || f_req || d_req) chk({tag, "_timeout"}, 64'd1, 64'd0);
        repeat (2) tick();
    endtask

    initial begin
        int t0, fg0, dg0, dv0, n;
        reset = 1'b0; halt = 1'b0; f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
        f_addr_dir = tinker_arb_pkg::MEM_TEXT_BASE;
        d_addr_dir = 64'h80000; d_wdata_dir = '0; d_we_dir = 1'b0;
        wr64(tinker_arb_pkg::MEM_TEXT_BASE, 64'h0000_0000_1100_0000);
        wr64(64'h80000, 64'hDEADBEEF_01234567);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Fetch only, L=3.
        fixed_lat = 3;
        f_req = 1'b1; f_addr = tinker_arb_pkg::MEM_TEXT_BASE; f_mode = 3; t0 = cyc;
        wait_idle("t1", 50);
        chk("t1_gnt_lat", 64'(last_f_gnt_cyc - t0), 64'd1);
        chk("t1_valid_lat", 64'(last_f_valid_cyc - t0), 64'd4);
        chk("t1_rdata", 64'(f_rdata), 64'h1100_0000);

        // Simultaneous fetch and load, L=1: data first.
        fixed_lat = 1; gq.delete();
        f_req = 1'b1; f_addr = tinker_arb_pkg::MEM_TEXT_BASE; f_mode = 3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h80000; d_mode = 3; d_addr_dir = 64'h80000; d_we_dir = 1'b0;
        wait_idle("t2", 50);
        chk("t2_first", 64'(gq_at(0)), 64'd2);
        chk("t2_second", 64'(gq_at(1)), 64'd1);
        chk("t2_d_rdata", d_rdata, 64'hDEADBEEF_01234567);

        // Continuous data with fetch waiting: four data grants, then a forced fetch.
        fixed_lat = 0; gq.delete();
        f_mode = 2; d_mode = 2; f_req = 1'b1; f_addr = f_addr_dir;
        d_req = 1'b1; d_we = 1'b0; d_addr = d_addr_dir;
        n = 0;
        while (gq.size() < 15 && n < 600) begin tick(); n++; end
        f_mode = 0; d_mode = 0;
        wait_idle("t3", 100);
        for (int i = 0; i < 15; i++) chk("t3_seq", 64'(gq_at(i)), (i % 5 == 4) ? 64'd1 : 64'd2);

        // Halted core: fetch never granted while a store completes.
        halt = 1'b1; fg0 = f_gnt_cnt; fixed_lat = 2;
        f_req = 1'b1; f_addr = tinker_arb_pkg::MEM_TEXT_BASE;
        d_addr_dir = 64'h80008; d_we_dir = 1'b1; d_wdata_dir = 64'h5; d_mode = 3;
        d_req = 1'b1; d_addr = d_addr_dir; d_we = 1'b1; d_wdata = 64'h5;
        n = 0;
        while ((d_req || inflight) && n < 100) begin tick(); n++; end
        repeat (10) tick();
        chk("t4_no_fgnt", 64'(f_gnt_cnt - fg0), 64'd0);
        chk("t4_store", rd64(64'h80008), 64'h5);
        chk("t4_neighbour", rd64(64'h80000), 64'hDEADBEEF_01234567);
        halt = 1'b0; f_mode = 3;
        wait_idle("t4", 50);
        chk("t4_fetch_after", 64'(f_gnt_cnt - fg0), 64'd1);

        // Reset mid-load with L=10: abandoned, no valid.
        fixed_lat = 10; dg0 = d_gnt_cnt;
        d_addr_dir = 64'h80000; d_we_dir = 1'b0; d_mode = 3;
        d_req = 1'b1; d_addr = d_addr_dir; d_we = 1'b0;
        n = 0;
        while (d_gnt_cnt == dg0 && n < 50) begin tick(); n++; end
        if (d_gnt_cnt == dg0) chk("t5_gnt_timeout", 64'd1, 64'd0);
        repeat (3) tick();
        reset = 1'b0; d_req = 1'b0; d_mode = 0; f_req = 1'b0; dv0 = d_valid_cnt;
        repeat (2) tick();
        reset = 1'b1;
        repeat (15) tick();
        chk("t5_no_dvalid", 64'(d_valid_cnt - dv0), 64'd0);
        fixed_lat = 2;
        f_req = 1'b1; f_addr = tinker_arb_pkg::MEM_TEXT_BASE; f_mode = 3;
        wait_idle("t5", 50);
        chk("t5_fetch", 64'(f_rdata), 64'h1100_0000);

        // Stray m_ack while idle.
        m_ack = 1'b1;
        tick();
        repeat (3) tick();
        chk("t6_busy", 64'(busy), 64'd0);

        // Random traffic.
        fixed_lat = 0; f_mode = 1; d_mode = 1;
        repeat (2500) begin
            tick();
            halt = ($urandom_range(0, 4) == 0);
        end
        f_mode = 0; d_mode = 0; halt = 1'b0;
        wait_idle("t7", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
